// File: rtl/riscv_pkg.sv
// Shared encodings for the execute stage: ALU operation codes and operand
// forwarding selects, plus the forwarding mux helper.
package riscv_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Code 11 is unused by the hazard unit and falls back to the register value.
  function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                          input logic [31:0] reg_val,
                                          input logic [31:0] wb_val,
                                          input logic [31:0] mem_val);
    case (sel)
      FWD_REG: fwd_mux = reg_val;
      FWD_WB:  fwd_mux = wb_val;
      FWD_MEM: fwd_mux = mem_val;
      default: fwd_mux = reg_val;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU: add/sub/and/or wrap modulo 2^DATA_W, slt is a
// signed compare; undefined op codes yield zero.
module alu
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [2:0]        ALUControl,
  output logic [DATA_W-1:0] Result,
  output logic              Zero
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;

  assign a_s = A;
  assign b_s = B;

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = A + B;
      ALU_SUB: Result = A - B;
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_SLT: Result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// RISC-V execute stage: operand forwarding, ALU, branch resolution and the
// E->M pipeline register.
module execute_cycle
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        BranchE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [4:0]  RD_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [31:0] ResultW,
  input  logic [1:0]  ForwardA_E,
  input  logic [1:0]  ForwardB_E,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] WriteDataM,
  output logic [31:0] ALU_ResultM,
  output logic [31:0] PCPlus4M
);

  logic [31:0] src_a;
  logic [31:0] write_data;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        zero;

  // Forwarding from M uses the registered result, covering back-to-back dependences.
  assign src_a      = fwd_mux(ForwardA_E, RD1_E, ResultW, ALU_ResultM);
  assign write_data = fwd_mux(ForwardB_E, RD2_E, ResultW, ALU_ResultM);
  assign src_b      = ALUSrcE ? Imm_Ext_E : write_data;

  alu #(
    .DATA_W(32)
  ) u_alu (
    .A         (src_a),
    .B         (src_b),
    .ALUControl(ALUControlE),
    .Result    (alu_result),
    .Zero      (zero)
  );

  assign PCSrcE    = BranchE & zero;
  assign PCTargetE = PCE + Imm_Ext_E;

  // ---- E -> M stage boundary ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= 5'h00;
      WriteDataM  <= 32'h0;
      ALU_ResultM <= 32'h0;
      PCPlus4M    <= 32'h0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      WriteDataM  <= write_data;
      ALU_ResultM <= alu_result;
      PCPlus4M    <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: behavioural reference model compared
// every cycle, plus directed cases with hand-computed expectations.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] WriteDataM, ALU_ResultM, PCPlus4M;

  int ntests = 0;
  int nfail  = 0;
  bit chk_en = 1'b0;

  // Model of the M-stage state
  logic        m_rw = 1'b0, m_mw = 1'b0, m_rs = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_wd = '0, m_alu = '0, m_pc4 = '0;

  always #5 clk = ~clk;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .PCPlus4M(PCPlus4M)
  );

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 3'd0) return a + b;
    if (op == 3'd1) return a - b;
    if (op == 3'd2) return a & b;
    if (op == 3'd3) return a | b;
    if (op == 3'd5) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  function automatic logic [31:0] ref_operand(input logic [1:0] code, input logic [31:0] r);
    if (code == 2'd1) return ResultW;
    if (code == 2'd2) return m_alu;
    return r;
  endfunction

  function automatic logic [31:0] ref_store();
    return ref_operand(ForwardB_E, RD2_E);
  endfunction

  function automatic logic [31:0] ref_result();
    return ref_alu(ALUControlE, ref_operand(ForwardA_E, RD1_E),
                   ALUSrcE ? Imm_Ext_E : ref_store());
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    ntests++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Model advance at each clock edge
  always @(posedge clk) begin
    if (!rst) begin
      m_rw <= 1'b0; m_mw <= 1'b0; m_rs <= 1'b0; m_rd <= '0;
      m_wd <= '0; m_alu <= '0; m_pc4 <= '0;
    end else begin
      m_rw <= RegWriteE; m_mw <= MemWriteE; m_rs <= ResultSrcE; m_rd <= RD_E;
      m_wd <= ref_store(); m_alu <= ref_result(); m_pc4 <= PCPlus4E;
    end
  end

  // Compare process, mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("PCSrcE",      {31'd0, PCSrcE}, {31'd0, BranchE & (ref_result() == 32'd0)});
      check("PCTargetE",   PCTargetE, PCE + Imm_Ext_E);
      check("RegWriteM",   {31'd0, RegWriteM}, {31'd0, m_rw});
      check("MemWriteM",   {31'd0, MemWriteM}, {31'd0, m_mw});
      check("ResultSrcM",  {31'd0, ResultSrcM}, {31'd0, m_rs});
      check("RD_M",        {27'd0, RD_M}, {27'd0, m_rd});
      check("WriteDataM",  WriteDataM, m_wd);
      check("ALU_ResultM", ALU_ResultM, m_alu);
      check("PCPlus4M",    PCPlus4M, m_pc4);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
    ALUControlE = 3'b000; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0;
    PCE = 0; PCPlus4E = 0; ResultW = 0; ForwardA_E = 0; ForwardB_E = 0;
  endtask

  task automatic rand_inputs();
    RegWriteE = 1'($urandom); ALUSrcE = 1'($urandom); MemWriteE = 1'($urandom);
    ResultSrcE = 1'($urandom); BranchE = 1'($urandom);
    ALUControlE = 3'($urandom);
    RD1_E = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
    RD2_E = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
    Imm_Ext_E = $urandom; RD_E = 5'($urandom);
    PCE = $urandom; PCPlus4E = PCE + 32'd4; ResultW = $urandom;
    ForwardA_E = 2'($urandom); ForwardB_E = 2'($urandom);
  endtask

  initial begin
    rst = 1'b0;
    rand_inputs();
    tick();
    chk_en = 1'b1;
    // Reset with nonzero inputs
    check("rst_ALU_ResultM", ALU_ResultM, 32'h0);
    check("rst_RD_M", {27'd0, RD_M}, 32'h0);
    check("rst_PCPlus4M", PCPlus4M, 32'h0);
    check("rst_RegWriteM", {31'd0, RegWriteM}, 32'h0);

    rst = 1'b1;
    clear_inputs();
    RD1_E = 5; Imm_Ext_E = 7; ALUSrcE = 1; RD_E = 3; RegWriteE = 1;
    tick();
    check("addi_ALU_ResultM", ALU_ResultM, 32'd12);
    check("addi_RD_M", {27'd0, RD_M}, 32'd3);
    check("addi_RegWriteM", {31'd0, RegWriteM}, 32'd1);

    clear_inputs();
    BranchE = 1; ALUControlE = 3'b001; RD1_E = 9; RD2_E = 9; PCE = 32'h100; Imm_Ext_E = 32'hFFFFFFF0;
    #1;
    check("beq_taken", {31'd0, PCSrcE}, 32'd1);
    check("beq_target", PCTargetE, 32'hF0);
    RD2_E = 8;
    #1;
    check("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
    PCE = 32'hFFFFFFFC; Imm_Ext_E = 32'd8;
    #1;
    check("target_wrap", PCTargetE, 32'h4);

    clear_inputs();
    RD1_E = 20; ALUSrcE = 1; Imm_Ext_E = 0;
    tick();
    check("fwd_setup", ALU_ResultM, 32'd20);
    clear_inputs();
    ForwardA_E = 2'b10; RD1_E = 99; RD2_E = 1; ALUControlE = 3'b001;
    tick();
    check("fwdA_mem_sub", ALU_ResultM, 32'd19);
    clear_inputs();
    ForwardB_E = 2'b01; ResultW = 44; MemWriteE = 1; RD2_E = 5;
    tick();
    check("fwdB_wb_store", WriteDataM, 32'd44);
    check("fwdB_MemWriteM", {31'd0, MemWriteM}, 32'd1);
    clear_inputs();
    ForwardA_E = 2'b11; RD1_E = 6; ResultW = 100; RD2_E = 4;
    tick();
    check("fwd11_is_reg", ALU_ResultM, 32'd10);

    clear_inputs();
    RD1_E = 32'hFFFFFFFF; RD2_E = 1; ALUControlE = 3'b101;
    tick();
    check("slt_signed", ALU_ResultM, 32'd1);
    ALUControlE = 3'b000;
    tick();
    check("add_wrap", ALU_ResultM, 32'd0);
    RD1_E = 5; RD2_E = 3; ALUControlE = 3'b111;
    tick();
    check("undef_op", ALU_ResultM, 32'd0);

    // Randomized traffic with occasional mid-stream reset
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 19) != 0);
      tick();
    end
    rst = 1'b1;
    tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 SHALL have clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  in  1 each  E-stage control bits from decode pipeline register.
REQ-004 SHALL have ALUControlE  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt; other codes produce 0.
REQ-005 SHALL have RD1_E, RD2_E  in  32 each  register operands.
REQ-006 SHALL have Imm_Ext_E  in  32  sign-extended immediate.
REQ-007 SHALL have RD_E  in  5  destination register index.
REQ-008 SHALL have PCE, PCPlus4E  in  32 each  instruction PC and PC+4.
REQ-009 SHALL have ResultW  in  32  writeback result for forwarding.
REQ-010 SHALL have ForwardA_E, ForwardB_E  in  2 each  operand select: 00 register, 01 ResultW, 10 ALU_ResultM, 11 register.
REQ-011 SHALL have PCSrcE  out  1  branch taken, combinational.
REQ-012 SHALL have PCTargetE  out  32  branch target, combinational.
REQ-013 SHALL have RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered control.
REQ-014 SHALL have RD_M  out  5  registered destination.
REQ-015 SHALL have WriteDataM, ALU_ResultM, PCPlus4M  out  32 each  registered store data, ALU result, PC+4.

Function
REQ-016 SrcA SHALL be ForwardA_E-selected operand; WriteData SHALL be ForwardB_E-selected operand.
REQ-017 SrcB SHALL be Imm_Ext_E when ALUSrcE=1, else forwarded WriteData.
REQ-018 ALU SHALL compute modulo 2^32; carries discarded; slt signed, result 32'h1 or 32'h0.
REQ-019 Zero SHALL be 1 iff ALU result equals 32'h0.
REQ-020 PCSrcE SHALL equal BranchE AND Zero, same cycle as inputs.
REQ-021 PCTargetE SHALL equal PCE + Imm_Ext_E modulo 2^32, wrap allowed (32'hFFFFFFFC + 8 = 32'h4).
REQ-022 On each posedge with rst=1 all M outputs SHALL capture E-stage values: latency exactly 1 cycle, no stall/enable.
REQ-023 Forward code 10 SHALL use the current registered ALU_ResultM, i.e. result of previous instruction (back-to-back dependence).
REQ-024 Forward code 11 SHALL behave as 00.
REQ-025 Inputs RegWriteE and control bits SHALL not affect PCSrcE/PCTargetE beyond REQ-020/021.

Reset
REQ-026 When rst=0 at posedge, every M-stage register SHALL become 0 (RegWriteM, MemWriteM, ResultSrcM = 0; RD_M = 5'h00; WriteDataM, ALU_ResultM, PCPlus4M = 32'h0); reset mid-stream discards the in-flight instruction.
REQ-027 PCSrcE and PCTargetE SHALL remain combinational and unaffected by rst.

Structure
REQ-028 ALU op codes and forward-select codes SHALL live in shared package riscv_pkg.
REQ-029 ALU SHALL be sub-module alu (inputs A, B, ALUControl; outputs Result, Zero); muxes and pipeline register stay in execute_cycle.

Verification
REQ-030 Reset: rst=0 one cycle with nonzero inputs -> all M outputs 0 next cycle.
REQ-031 Add/imm: RD1_E=5, Imm_Ext_E=7, ALUSrcE=1, ALUControlE=000, RD_E=3, RegWriteE=1 -> next cycle ALU_ResultM=12, RD_M=3, RegWriteM=1.
REQ-032 Branch: BranchE=1, ALUControlE=001, RD1_E=RD2_E=9, PCE=32'h100, Imm_Ext_E=32'hFFFFFFF0 -> PCSrcE=1, PCTargetE=32'hF0; RD2_E=8 -> PCSrcE=0.
REQ-033 Forwarding: cycle N ALU_ResultM=20; ForwardA_E=10, RD2_E=1, sub -> ALU_ResultM=19; ForwardB_E=01, ResultW=44, MemWriteE=1 -> WriteDataM=44.
REQ-034 slt/wrap: RD1_E=32'hFFFFFFFF, RD2_E=1, slt -> 1; add 32'hFFFFFFFF+1 -> 0; ALUControlE=111 -> 0.
